// File: rtl/decode_stage.sv
// RV32I decode stage: registers decoded fields and control for execute.
// Ports: IF packet in (vld/data), registered stall out, execute stall/flush in, decoded bundle out.
module decode_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int PKT_WIDTH  = ADDR_WIDTH + INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_if_pkt_vld,
    input  logic [PKT_WIDTH-1:0]  i_if_pkt_data,
    output logic                  o_stall,
    input  logic                  i_stall,
    input  logic                  i_flush,
    output logic                  o_id_vld,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [4:0]            o_rs1,
    output logic [4:0]            o_rs2,
    output logic [4:0]            o_rd,
    output logic [2:0]            o_funct3,
    output logic [31:0]           o_imm,
    output logic [3:0]            o_alu_op,
    output logic                  o_src_a_pc,
    output logic                  o_src_b_imm,
    output logic                  o_reg_wr,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic                  o_branch,
    output logic                  o_jump,
    output logic                  o_illegal
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_FENCE = 7'b0001111;

    logic                 skid_full;
    logic [PKT_WIDTH-1:0] skid_pkt;
    logic                 accept;
    logic                 advance;
    logic                 src_vld;
    logic [PKT_WIDTH-1:0] src_pkt;
    logic [31:0]          inst;
    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [31:0]          imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]           f3_alu;

    logic [31:0] imm;
    logic [3:0]  alu;
    logic        a_pc, b_imm, reg_wr, mem_rd, mem_wr, branch, jump, illegal;

    assign o_stall = skid_full;
    assign accept  = i_if_pkt_vld && !skid_full;
    assign advance = !o_id_vld || !i_stall;
    // The skid always holds the oldest packet, so it wins the output slot.
    assign src_pkt = skid_full ? skid_pkt : i_if_pkt_data;
    assign src_vld = skid_full || accept;

    assign inst   = src_pkt[INST_WIDTH-1:0];
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // inst[30] only selects SRA/SUB; legality checks reject every other funct7.
    always_comb begin
        f3_alu = ALU_ADD;
        unique case (f3)
            3'b000: f3_alu = ALU_ADD;
            3'b001: f3_alu = ALU_SLL;
            3'b010: f3_alu = ALU_SLT;
            3'b011: f3_alu = ALU_SLTU;
            3'b100: f3_alu = ALU_XOR;
            3'b101: f3_alu = inst[30] ? ALU_SRA : ALU_SRL;
            3'b110: f3_alu = ALU_OR;
            3'b111: f3_alu = ALU_AND;
            default: f3_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        imm     = '0;
        alu     = ALU_ADD;
        a_pc    = 1'b0;
        b_imm   = 1'b0;
        reg_wr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        illegal = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                imm = imm_u; alu = ALU_PASS; b_imm = 1'b1; reg_wr = 1'b1;
            end
            OPC_AUIPC: begin
                imm = imm_u; a_pc = 1'b1; b_imm = 1'b1; reg_wr = 1'b1;
            end
            OPC_JAL: begin
                imm = imm_j; a_pc = 1'b1; jump = 1'b1; reg_wr = 1'b1;
            end
            OPC_JALR: begin
                imm = imm_i; a_pc = 1'b1; jump = 1'b1; reg_wr = 1'b1;
                illegal = (f3 != 3'b000);
            end
            OPC_BR: begin
                imm = imm_b; alu = ALU_SUB; branch = 1'b1;
                illegal = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                imm = imm_i; b_imm = 1'b1; mem_rd = 1'b1; reg_wr = 1'b1;
                illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                imm = imm_s; b_imm = 1'b1; mem_wr = 1'b1;
                illegal = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                imm = imm_i; b_imm = 1'b1; reg_wr = 1'b1; alu = f3_alu;
                illegal = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OPC_OP: begin
                reg_wr = 1'b1;
                alu = (f3 == 3'b000 && inst[30]) ? ALU_SUB : f3_alu;
                illegal = !((f7 == 7'h00) ||
                            ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_FENCE: begin
                imm = '0;
            end
            default: illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) illegal = 1'b1;
        if (illegal) begin
            imm    = '0;
            alu    = ALU_ADD;
            a_pc   = 1'b0;
            b_imm  = 1'b0;
            reg_wr = 1'b0;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            branch = 1'b0;
            jump   = 1'b0;
        end
        if (inst[11:7] == 5'd0) reg_wr = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full   <= 1'b0;
            skid_pkt    <= '0;
            o_id_vld    <= 1'b0;
            o_pc        <= '0;
            o_rs1       <= '0;
            o_rs2       <= '0;
            o_rd        <= '0;
            o_funct3    <= '0;
            o_imm       <= '0;
            o_alu_op    <= '0;
            o_src_a_pc  <= 1'b0;
            o_src_b_imm <= 1'b0;
            o_reg_wr    <= 1'b0;
            o_mem_rd    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_branch    <= 1'b0;
            o_jump      <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_flush) begin
            skid_full <= 1'b0;
            o_id_vld  <= 1'b0;
        end else if (advance) begin
            skid_full <= 1'b0;
            o_id_vld  <= src_vld;
            if (src_vld) begin
                o_pc        <= src_pkt[PKT_WIDTH-1:INST_WIDTH];
                o_rs1       <= inst[19:15];
                o_rs2       <= inst[24:20];
                o_rd        <= inst[11:7];
                o_funct3    <= f3;
                o_imm       <= imm;
                o_alu_op    <= alu;
                o_src_a_pc  <= a_pc;
                o_src_b_imm <= b_imm;
                o_reg_wr    <= reg_wr;
                o_mem_rd    <= mem_rd;
                o_mem_wr    <= mem_wr;
                o_branch    <= branch;
                o_jump      <= jump;
                o_illegal   <= illegal;
            end
        end else if (accept) begin
            skid_full <= 1'b1;
            skid_pkt  <= i_if_pkt_data;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed spec scenarios plus random traffic
// checked against a queue-based occupancy model and a rule-based decoder.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_if_pkt_vld = 1'b0;
    logic [63:0] i_if_pkt_data = '0;
    logic        o_stall;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_id_vld;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1, o_rs2, o_rd;
    logic [2:0]  o_funct3;
    logic [31:0] o_imm;
    logic [3:0]  o_alu_op;
    logic        o_src_a_pc, o_src_b_imm, o_reg_wr, o_mem_rd, o_mem_wr;
    logic        o_branch, o_jump, o_illegal;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_pkt_vld(i_if_pkt_vld), .i_if_pkt_data(i_if_pkt_data),
        .o_stall(o_stall), .i_stall(i_stall), .i_flush(i_flush),
        .o_id_vld(o_id_vld), .o_pc(o_pc),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_funct3(o_funct3),
        .o_imm(o_imm), .o_alu_op(o_alu_op),
        .o_src_a_pc(o_src_a_pc), .o_src_b_imm(o_src_b_imm),
        .o_reg_wr(o_reg_wr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
        .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        a_pc, b_imm, reg_wr, mem_rd, mem_wr, br, j, ill;
    } ctl_t;

    int total = 0;
    int bad = 0;
    logic [63:0] q[$];

    wire [95:0] all_out = {o_id_vld, o_stall, o_pc, o_rs1, o_rs2, o_rd,
                           o_funct3, o_imm, o_alu_op, o_src_a_pc, o_src_b_imm,
                           o_reg_wr, o_mem_rd, o_mem_wr, o_branch, o_jump, o_illegal};
    wire [43:0] ctl_out = {o_imm, o_alu_op, o_src_a_pc, o_src_b_imm, o_reg_wr,
                           o_mem_rd, o_mem_wr, o_branch, o_jump, o_illegal};

    function automatic int sext(int v, int bits);
        int t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    function automatic logic [3:0] alu_of(int f3, bit alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 5 && alt) return 4'd7;
        return tbl[f3];
    endfunction

    function automatic ctl_t model(logic [31:0] inst);
        ctl_t c;
        int x, op, f3, f7, rd;
        x  = inst;
        op = x & 127;
        f3 = (x >> 12) & 7;
        f7 = (x >> 25) & 127;
        rd = (x >> 7) & 31;
        c  = '0;
        case (op)
            'h37: begin c.imm = x & 32'hFFFFF000; c.alu = 10; c.b_imm = 1; c.reg_wr = 1; end
            'h17: begin c.imm = x & 32'hFFFFF000; c.a_pc = 1; c.b_imm = 1; c.reg_wr = 1; end
            'h6f: begin
                c.imm = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                             (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
                c.a_pc = 1; c.j = 1; c.reg_wr = 1;
            end
            'h67: begin
                c.imm = sext(x >> 20, 12); c.a_pc = 1; c.j = 1; c.reg_wr = 1;
                c.ill = (f3 != 0);
            end
            'h63: begin
                c.imm = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                             (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
                c.alu = 1; c.br = 1; c.ill = (f3 == 2 || f3 == 3);
            end
            'h03: begin
                c.imm = sext(x >> 20, 12); c.b_imm = 1; c.mem_rd = 1; c.reg_wr = 1;
                c.ill = (f3 == 3 || f3 >= 6);
            end
            'h23: begin
                c.imm = sext((((x >> 25) & 127) << 5) | ((x >> 7) & 31), 12);
                c.b_imm = 1; c.mem_wr = 1; c.ill = (f3 > 2);
            end
            'h13: begin
                c.imm = sext(x >> 20, 12); c.b_imm = 1; c.reg_wr = 1;
                c.alu = alu_of(f3, f7 == 'h20);
                c.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
            end
            'h33: begin
                c.reg_wr = 1;
                c.alu = (f3 == 0 && f7 == 'h20) ? 4'd1 : alu_of(f3, f7 == 'h20);
                c.ill = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
            end
            'h0f: c.imm = 0;
            default: c.ill = 1;
        endcase
        if (c.ill) begin
            c = '0;
            c.ill = 1;
        end
        if (rd == 0) c.reg_wr = 0;
        return c;
    endfunction

    task automatic drive(bit vld, logic [63:0] data, bit stall, bit flush);
        i_if_pkt_vld  = vld;
        i_if_pkt_data = data;
        i_stall       = stall;
        i_flush       = flush;
    endtask

    // q[0] is the entry on the outputs, q[1] the one parked in the skid.
    task automatic tick();
        bit acc, cons;
        acc  = i_if_pkt_vld && (q.size() < 2);
        cons = (q.size() > 0) && !i_stall;
        if (i_flush) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(i_if_pkt_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(string tag);
        bit ev, es;
        ctl_t c;
        ev = (q.size() > 0);
        es = (q.size() == 2);
        total++;
        if ({o_id_vld, o_stall} !== {ev, es}) begin
            bad++;
            $display("FAIL %s vld/stall got %b%b want %b%b", tag, o_id_vld, o_stall, ev, es);
        end
        if (ev) begin
            c = model(q[0][31:0]);
            total++;
            if ({o_pc, o_rs1, o_rs2, o_rd, o_funct3} !==
                {q[0][63:32], q[0][19:15], q[0][24:20], q[0][11:7], q[0][14:12]}) begin
                bad++;
                $display("FAIL %s fields got pc=%h rs1=%0d rs2=%0d rd=%0d f3=%0d want pkt %h",
                         tag, o_pc, o_rs1, o_rs2, o_rd, o_funct3, q[0]);
            end
            total++;
            if (ctl_out !== c) begin
                bad++;
                $display("FAIL %s ctl got %h want %h inst %h", tag, ctl_out, c, q[0][31:0]);
            end
        end
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0);
        rst_n = 1'b0;
        q.delete();
        #1;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset outputs got %h want 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        check_model("reset_idle");
    endtask

    task automatic test_addi();
        drive(1, {32'h0, 32'h00500093}, 0, 0);
        tick();
        drive(0, '0, 0, 0);
        total++;
        if ({o_id_vld, o_rd, o_rs1, o_imm} !== {1'b1, 5'd1, 5'd0, 32'd5}) begin
            bad++;
            $display("FAIL addi fields got vld=%b rd=%0d rs1=%0d imm=%h want 1 1 0 5",
                     o_id_vld, o_rd, o_rs1, o_imm);
        end
        total++;
        if ({o_alu_op, o_src_b_imm, o_reg_wr, o_illegal} !== {4'd0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL addi ctl got alu=%0d bimm=%b wr=%b ill=%b want 0 1 1 0",
                     o_alu_op, o_src_b_imm, o_reg_wr, o_illegal);
        end
        tick();
        check_model("addi_drain");
    endtask

    task automatic test_branch();
        drive(1, {32'h100, 32'hFE208EE3}, 0, 0);
        tick();
        drive(0, '0, 0, 0);
        total++;
        if ({o_pc, o_imm, o_rs1, o_rs2} !== {32'h100, 32'hFFFFFFFC, 5'd1, 5'd2}) begin
            bad++;
            $display("FAIL beq fields got pc=%h imm=%h rs1=%0d rs2=%0d want 100 fffffffc 1 2",
                     o_pc, o_imm, o_rs1, o_rs2);
        end
        total++;
        if ({o_branch, o_alu_op, o_reg_wr, o_jump} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL beq ctl got br=%b alu=%0d wr=%b j=%b want 1 1 0 0",
                     o_branch, o_alu_op, o_reg_wr, o_jump);
        end
        tick();
    endtask

    task automatic test_skid();
        logic [95:0] held;
        drive(1, {32'h200, 32'h00100113}, 0, 0);
        tick();
        drive(1, {32'h204, 32'h00200193}, 1, 0);
        tick();
        held = all_out;
        total++;
        if ({o_id_vld, o_stall, o_pc} !== {1'b1, 1'b1, 32'h200}) begin
            bad++;
            $display("FAIL skid_fill got vld=%b stall=%b pc=%h want 1 1 200", o_id_vld, o_stall, o_pc);
        end
        drive(1, {32'h208, 32'h00300213}, 1, 0);
        tick();
        tick();
        total++;
        if (all_out !== held) begin
            bad++;
            $display("FAIL skid_hold got %h want %h", all_out, held);
        end
        drive(0, '0, 0, 0);
        tick();
        total++;
        if ({o_id_vld, o_stall, o_pc, o_rd} !== {1'b1, 1'b0, 32'h204, 5'd3}) begin
            bad++;
            $display("FAIL skid_drain got vld=%b stall=%b pc=%h rd=%0d want 1 0 204 3",
                     o_id_vld, o_stall, o_pc, o_rd);
        end
        tick();
        check_model("skid_empty");
    endtask

    task automatic test_illegal();
        logic [31:0] bad_inst [2];
        bad_inst = '{32'hFFFFFFFF, 32'h00000010};
        foreach (bad_inst[k]) begin
            drive(1, {32'h300, bad_inst[k]}, 0, 0);
            tick();
            drive(0, '0, 0, 0);
            total++;
            if ({o_id_vld, o_illegal, o_reg_wr, o_mem_rd, o_mem_wr, o_branch, o_jump} !==
                7'b1100000) begin
                bad++;
                $display("FAIL illegal_%0d got vld=%b ill=%b wr=%b mrd=%b mwr=%b br=%b j=%b",
                         k, o_id_vld, o_illegal, o_reg_wr, o_mem_rd, o_mem_wr, o_branch, o_jump);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1, {32'h400, 32'h00100093}, 0, 0);
        tick();
        drive(1, {32'h404, 32'h00200093}, 1, 0);
        tick();
        drive(1, {32'h408, 32'h00300093}, 1, 1);
        tick();
        drive(0, '0, 0, 0);
        total++;
        if ({o_id_vld, o_stall} !== 2'b00) begin
            bad++;
            $display("FAIL flush got vld=%b stall=%b want 0 0", o_id_vld, o_stall);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_id_vld !== 1'b0) begin
                bad++;
                $display("FAIL flush_ghost got vld=%b pc=%h want vld 0", o_id_vld, o_pc);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, {32'h500, 32'h00100093}, 0, 0);
        tick();
        drive(1, {32'h504, 32'h00200093}, 1, 0);
        tick();
        #2;
        do_reset();
        drive(1, {32'h600, 32'h00500093}, 0, 0);
        tick();
        drive(0, '0, 0, 0);
        total++;
        if ({o_id_vld, o_stall, o_pc, o_rd, o_imm} !== {1'b1, 1'b0, 32'h600, 5'd1, 32'd5}) begin
            bad++;
            $display("FAIL post_reset got vld=%b stall=%b pc=%h rd=%0d imm=%h",
                     o_id_vld, o_stall, o_pc, o_rd, o_imm);
        end
        tick();
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0] ops [10];
        logic [31:0] v;
        int k;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f};
        v = $urandom;
        k = $urandom_range(0, 11);
        if (k < 10) v[6:0] = ops[k];
        if (k == 10) v[6:0] = 7'h73;
        if ((v[6:0] == 7'h33 || v[6:0] == 7'h13) && ($urandom_range(0, 3) != 0))
            v[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return v;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 7, {$urandom, gen_inst()},
                  $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0);
            tick();
            check_model("random");
        end
        drive(0, '0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check_model("random_drain");
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_skid();
        test_illegal();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
